mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: cycles Busy stays high for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: cycles Busy stays high for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request strobe, sampled on the clk edge.
REQ-006 MDUOp  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 A  input  32  operand A (rs): multiplicand, dividend or MTHI/MTLO data.
REQ-008 B  input  32  operand B (rt): multiplier or divisor.
REQ-009 Busy  output  1  high while a mult/div is in flight.
REQ-010 HI  output  32  HI register, registered output.
REQ-011 LO  output  32  LO register, registered output.

Function
REQ-012 The design SHALL use a two-state FSM: IDLE (Busy=0) and RUN (Busy=1), plus a down-counter.
REQ-013 In IDLE, a Start with MDUOp 000-011 SHALL latch A, B and MDUOp, enter RUN and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-014 Busy SHALL be high from the edge that accepts Start through the edge that writes the result; it SHALL be high for exactly MULT_CYCLES/DIV_CYCLES cycles.
REQ-015 On the final RUN edge, HI/LO SHALL be written and Busy SHALL deassert on that same edge, returning to IDLE.
REQ-016 HI/LO SHALL hold their previous values for the whole RUN period; no partial results are visible.
REQ-017 MULT SHALL compute the signed 64-bit product of latched A and B; MULTU SHALL compute the unsigned product; HI = bits 63:32, LO = bits 31:0.
REQ-018 DIV SHALL compute signed division: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
REQ-019 DIVU SHALL compute unsigned division: LO = quotient, HI = remainder.
REQ-020 DIV with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-021 Division with latched B=0 SHALL still run DIV_CYCLES cycles, and HI/LO SHALL remain unchanged at completion.
REQ-022 In IDLE, Start with MTHI SHALL write A to HI on that edge (LO unchanged); Start with MTLO SHALL write A to LO (HI unchanged); Busy SHALL stay 0.
REQ-023 Any Start while Busy=1 SHALL be ignored, including MTHI/MTLO; the in-flight operation SHALL be unaffected.
REQ-024 Start with reserved MDUOp 110/111 SHALL be ignored in any state.
REQ-025 Operand changes on A/B after Start is accepted SHALL NOT affect the result.
REQ-026 A new Start SHALL be accepted on the first edge after Busy falls; back-to-back operations SHALL be separated by no idle cycle beyond that.

Reset
REQ-027 While reset=1 at a clk edge, HI=0, LO=0, Busy=0, FSM=IDLE and counter=0, regardless of Start.
REQ-028 Reset asserted during RUN SHALL abort the operation; the discarded result is never written.
REQ-029 Start in the same cycle as reset SHALL be ignored.

Verification
REQ-030 MULT A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. A follow-up DIVU A=7, B=0 -> HI/LO unchanged after 10 cycles.
REQ-033 MTLO A=0x12345678 in IDLE -> next edge LO=0x12345678, Busy stays 0. A subsequent MULT, with MTHI A=0xDEAD issued at Busy cycle 2 -> MTHI ignored, and the MULT result lands on schedule.
REQ-034 Reset pulse at cycle 4 of a DIV -> HI=LO=0 and Busy=0 on the reset edge. After reset releases, no late write occurs within 10 cycles.
REQ-035 A, B and MDUOp are randomized on every cycle while Busy=1 -> the result matches the operands latched at Start.

Source files
------------

// File: rtl/mdu_if.sv
// Request/response bundle between a requester and the multiply/divide unit.
interface mdu_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDUOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// An accepted MULT/DIV latches its operands, holds Busy for a fixed number
// of cycles and writes HI/LO only on the final busy edge.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic        sgn_a, sgn_b, is_signed, is_div, div_by_zero;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, uq, ur;
  logic [31:0] res_hi, res_lo;

  // Result datapath from the latched operands; sign handled via magnitudes
  // so that 0x80000000 / -1 naturally wraps to 0x80000000 with remainder 0.
  always_comb begin
    is_signed   = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_div      = op_q[1];
    sgn_a       = is_signed & a_q[31];
    sgn_b       = is_signed & b_q[31];
    prod        = {{32{sgn_a}}, a_q} * {{32{sgn_b}}, b_q};
    mag_a       = sgn_a ? (~a_q + 32'd1) : a_q;
    mag_b       = sgn_b ? (~b_q + 32'd1) : b_q;
    div_by_zero = (b_q == 32'd0);
    uq          = div_by_zero ? 32'd0 : (mag_a / mag_b);
    ur          = div_by_zero ? 32'd0 : (mag_a % mag_b);
    if (is_div) begin
      res_lo = (sgn_a ^ sgn_b) ? (~uq + 32'd1) : uq;
      res_hi = sgn_a ? (~ur + 32'd1) : ur;
    end else begin
      res_lo = prod[31:0];
      res_hi = prod[63:32];
    end
  end

  // Next-state logic: accept requests in IDLE, count down in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          case (bus.MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = bus.MDUOp;
              a_d     = bus.A;
              b_d     = bus.B;
              state_d = RUN;
              cnt_d   = bus.MDUOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          // A zero divisor leaves HI/LO untouched.
          if (!(is_div && div_by_zero)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy = (state_q == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, randomized operations
// against a plain-arithmetic reference model, and reset/ignore sequences.
module tb_mdu;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  logic [31:0] hi_m, lo_m;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Reference model: architectural meaning of each op using 64-bit integers.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] res;
    res = {hi, lo};
    case (op)
      3'd0: begin
        sa = longint'(signed'(a)); sb = longint'(signed'(b)); p = sa * sb;
        res = 64'(p);
      end
      3'd1: begin
        sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); p = sa * sb;
        res = 64'(p);
      end
      3'd2: if (b != 0) begin
        sa = longint'(signed'(a)); sb = longint'(signed'(b));
        q = sa / sb; r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd3: if (b != 0) begin
        sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
        q = sa / sb; r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: res = {a, lo};
      3'd5: res = {hi, a};
      default: ;
    endcase
    return res;
  endfunction

  // Issue one request at a negedge; while busy, scribble random requests and
  // operands to show they are ignored. Returns the number of busy cycles seen.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    bus.Start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    cyc = 0;
    while (bus.Busy && cyc < 100) begin
      cyc++;
      bus.Start = 1'($urandom);
      bus.MDUOp = 3'($urandom_range(0, 7));
      bus.A = $urandom; bus.B = $urandom;
      @(negedge clk);
    end
    bus.Start = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [63:0] exp;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    n_vec = 0; n_err = 0;

    tbl[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[5]  = '{3'd5, 32'h12345678, 32'h0000AAAA, 32'h00000000, 32'h12345678, 0};
    tbl[6]  = '{3'd4, 32'hDEADBEEF, 32'h0000BBBB, 32'hDEADBEEF, 32'h12345678, 0};
    tbl[7]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    tbl[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[9]  = '{3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};
    tbl[10] = '{3'd2, 32'h00000000, 32'h00000000, 32'hC0000000, 32'h80000000, 10};

    // Reset with a concurrent MTLO/MTHI request that must be ignored.
    reset = 1'b1;
    bus.Start = 1'b1; bus.MDUOp = 3'd5; bus.A = 32'hFFFF0000; bus.B = 32'd0;
    repeat (2) @(negedge clk);
    bus.MDUOp = 3'd4;
    @(negedge clk);
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);
    bus.Start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Directed table, issued back-to-back.
    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      $display("vec %0d op=%0d a=%08h b=%08h -> hi=%08h lo=%08h busy=%0d",
               i, tbl[i].op, tbl[i].a, tbl[i].b, bus.HI, bus.LO, cyc);
      check($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].cycles));
      check($sformatf("tbl%0d_hi", i), bus.HI, tbl[i].hi);
      check($sformatf("tbl%0d_lo", i), bus.LO, tbl[i].lo);
    end
    hi_m = tbl[10].hi; lo_m = tbl[10].lo;

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = {28'd0, 4'($urandom)};
      exp = model(rop, ra, rb, hi_m, lo_m);
      do_op(rop, ra, rb, cyc);
      hi_m = exp[63:32]; lo_m = exp[31:0];
      $display("rnd %0d op=%0d a=%08h b=%08h -> hi=%08h lo=%08h busy=%0d",
               i, rop, ra, rb, bus.HI, bus.LO, cyc);
      check("rnd_cycles", 32'(cyc), (rop < 3'd2) ? 32'd5 : (rop < 3'd4) ? 32'd10 : 32'd0);
      check("rnd_hi", bus.HI, hi_m);
      check("rnd_lo", bus.LO, lo_m);
    end

    // Reserved opcode in IDLE changes nothing.
    bus.Start = 1'b1; bus.MDUOp = 3'd6; bus.A = 32'h55555555;
    @(negedge clk);
    bus.MDUOp = 3'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    $display("reserved ops -> busy=%0d hi=%08h lo=%08h", bus.Busy, bus.HI, bus.LO);
    check("rsv_busy", {31'd0, bus.Busy}, 32'd0);
    check("rsv_hi", bus.HI, hi_m);
    check("rsv_lo", bus.LO, lo_m);

    // MTLO, then MULT with an MTHI attempted at busy cycle 2.
    do_op(3'd5, 32'h12345678, 32'd0, cyc);
    check("mtlo_busy", {31'd0, bus.Busy}, 32'd0);
    check("mtlo_lo", bus.LO, 32'h12345678);
    bus.Start = 1'b1; bus.MDUOp = 3'd0; bus.A = 32'd6; bus.B = 32'hFFFFFFF9;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = 3'd4; bus.A = 32'h0000DEAD;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    check("mthi_busy_still", {31'd0, bus.Busy}, 32'd1);
    @(negedge clk);
    $display("mult+mthi -> busy=%0d hi=%08h lo=%08h", bus.Busy, bus.HI, bus.LO);
    check("mthi_busy_done", {31'd0, bus.Busy}, 32'd0);
    check("mthi_hi", bus.HI, 32'hFFFFFFFF);
    check("mthi_lo", bus.LO, 32'hFFFFFFD6);

    // Reset pulse at cycle 4 of a DIV aborts it for good.
    bus.Start = 1'b1; bus.MDUOp = 3'd3; bus.A = 32'd1000; bus.B = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("div reset -> busy=%0d hi=%08h lo=%08h", bus.Busy, bus.HI, bus.LO);
    check("abort_busy", {31'd0, bus.Busy}, 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.Busy !== 1'b0) begin
        check("abort_late_hi", bus.HI, 32'd0);
        check("abort_late_lo", bus.LO, 32'd0);
        check("abort_late_busy", {31'd0, bus.Busy}, 32'd0);
      end
    end
    check("post_abort_lo", bus.LO, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
